// File: rtl/nios_system_descriptor_fetch.sv
// Descriptor fetch engine: walks a linked chain of 4-word descriptors over an
// Avalon-MM read master and presents each hardware-owned descriptor on a valid/ready stream.
module nios_system_descriptor_fetch #(
  parameter int MAX_DESC = 256,
  parameter int ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] head_ptr,
  input  logic              abort,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_read,
  input  logic              m_waitrequest,
  input  logic              m_readdatavalid,
  input  logic [31:0]       m_readdata,
  output logic              desc_valid,
  input  logic              desc_ready,
  output logic [31:0]       desc_src,
  output logic [31:0]       desc_dst,
  output logic [31:0]       desc_len,
  output logic [31:0]       desc_ctrl,
  output logic              busy,
  output logic              done,
  output logic [2:0]        status,
  output logic              aborted
);

  localparam int CNT_W = $clog2(MAX_DESC + 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_CHECK, S_OUT, S_DONE} state_t;

  localparam logic [2:0] ST_EOC   = 3'b001;
  localparam logic [2:0] ST_NOOWN = 3'b010;
  localparam logic [2:0] ST_ERR   = 3'b100;

  state_t            state, next_state;
  logic [ADDR_W-1:0] ptr;
  logic [2:0]        issue_cnt, recv_cnt;
  logic              rd_hold;
  logic              abort_q;
  logic [CNT_W-1:0]  desc_cnt;
  logic [3:0][31:0]  words;
  logic [2:0]        status_q;
  logic              aborted_q;

  logic              abort_any, rd_accept, beat, drained, handshake;
  logic              own, eoc;
  logic [ADDR_W-1:0] next_ptr;
  logic              fin, fin_abort;
  logic [2:0]        fin_status;

  assign abort_any = abort | abort_q;
  // Once a request is stalled it must stay up even if abort arrives meanwhile.
  assign m_read    = (state == S_FETCH) && (issue_cnt != 3'd4) && (rd_hold || !abort_any);
  assign m_address = ptr + ADDR_W'(issue_cnt);
  assign rd_accept = m_read && !m_waitrequest;
  assign beat      = (state == S_FETCH) && m_readdatavalid && (recv_cnt != 3'd4);
  assign drained   = !m_read && ((recv_cnt == issue_cnt) ||
                                 (beat && (recv_cnt + 3'd1 == issue_cnt)));
  assign handshake = (state == S_OUT) && desc_ready;

  assign own      = words[3][31];
  assign eoc      = words[3][30];
  assign next_ptr = {words[3][ADDR_W-1:2], 2'b00};

  assign desc_valid = (state == S_OUT);
  assign desc_src   = words[0];
  assign desc_dst   = words[1];
  assign desc_len   = words[2];
  assign desc_ctrl  = words[3];
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);
  assign status     = status_q;
  assign aborted    = aborted_q;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    next_state = state;
    fin        = 1'b0;
    fin_status = 3'b000;
    fin_abort  = 1'b0;
    unique case (state)
      S_IDLE: if (start) next_state = S_FETCH;
      S_FETCH: begin
        if (abort_any && drained) begin
          next_state = S_DONE;
          fin        = 1'b1;
          fin_status = ST_ERR;
          fin_abort  = 1'b1;
        end else if (beat && (recv_cnt == 3'd3)) begin
          next_state = S_CHECK;
        end
      end
      S_CHECK: begin
        if (abort_any) begin
          next_state = S_DONE;
          fin        = 1'b1;
          fin_status = ST_ERR;
          fin_abort  = 1'b1;
        end else if (!own) begin
          next_state = S_DONE;
          fin        = 1'b1;
          fin_status = ST_NOOWN;
        end else begin
          next_state = S_OUT;
        end
      end
      S_OUT: begin
        if (handshake) begin
          if (abort_any) begin
            next_state = S_DONE;
            fin        = 1'b1;
            fin_status = ST_ERR;
            fin_abort  = 1'b1;
          end else if (eoc) begin
            next_state = S_DONE;
            fin        = 1'b1;
            fin_status = ST_EOC;
          end else if (desc_cnt == CNT_W'(MAX_DESC)) begin
            next_state = S_DONE;
            fin        = 1'b1;
            fin_status = ST_ERR;
          end else begin
            next_state = S_FETCH;
          end
        end
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      ptr       <= '0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      rd_hold   <= 1'b0;
      abort_q   <= 1'b0;
      desc_cnt  <= '0;
      // NOTE: the word buffer drives the desc_* outputs directly, so unlike a
      // plain storage array it is reset to give defined outputs out of reset.
      words     <= '0;
      status_q  <= '0;
      aborted_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; later assignments in this
      // block deliberately override earlier ones (counter reload beats increment).
      state   <= next_state;
      rd_hold <= m_read && m_waitrequest;

      if (abort && (state inside {S_FETCH, S_CHECK, S_OUT})) abort_q <= 1'b1;

      if (rd_accept) issue_cnt <= issue_cnt + 3'd1;

      if (beat) begin
        words[recv_cnt[1:0]] <= m_readdata;
        recv_cnt             <= recv_cnt + 3'd1;
      end

      if ((state == S_CHECK) && (next_state == S_OUT)) desc_cnt <= desc_cnt + CNT_W'(1);

      if (handshake && (next_state == S_FETCH)) begin
        ptr       <= next_ptr;
        issue_cnt <= '0;
        recv_cnt  <= '0;
      end

      if ((state == S_IDLE) && start) begin
        ptr       <= {head_ptr[ADDR_W-1:2], 2'b00};
        issue_cnt <= '0;
        recv_cnt  <= '0;
        rd_hold   <= 1'b0;
        abort_q   <= 1'b0;
        desc_cnt  <= '0;
        status_q  <= '0;
        aborted_q <= 1'b0;
      end

      if (fin) begin
        status_q  <= fin_status;
        aborted_q <= fin_abort;
      end
    end
  end

endmodule

// File: tb/tb_nios_system_descriptor_fetch.sv
// Self-checking bench: Avalon memory model with random stalls, descriptor scoreboard,
// table-driven chain walks plus hand sequences for timing, abort and reset.
module tb_nios_system_descriptor_fetch;

  localparam int AW   = 10;
  localparam int MAXD = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] head_ptr = '0;
  logic          abort = 1'b0;
  logic [AW-1:0] m_address;
  logic          m_read;
  logic          m_waitrequest = 1'b0;
  logic          m_readdatavalid = 1'b0;
  logic [31:0]   m_readdata = '0;
  logic          desc_valid;
  logic          desc_ready = 1'b0;
  logic [31:0]   desc_src, desc_dst, desc_len, desc_ctrl;
  logic          busy, done, aborted;
  logic [2:0]    status;

  nios_system_descriptor_fetch #(.MAX_DESC(MAXD), .ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .head_ptr(head_ptr), .abort(abort),
    .m_address(m_address), .m_read(m_read), .m_waitrequest(m_waitrequest),
    .m_readdatavalid(m_readdatavalid), .m_readdata(m_readdata),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_src(desc_src), .desc_dst(desc_dst), .desc_len(desc_len), .desc_ctrl(desc_ctrl),
    .busy(busy), .done(done), .status(status), .aborted(aborted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] src, dst, len, ctrl;
  } desc_t;

  typedef struct {
    logic [AW-1:0] head;
    int            wait_pct;
    int            ready_pct;
    logic [2:0]    exp_status;
    int            exp_count;
  } vec_t;

  logic [31:0]   mem [0:1023];
  desc_t         exp_q[$];
  logic [AW-1:0] addr_q[$];
  logic [31:0]   resp_q[$];

  int            checks = 0, errors = 0;
  int            wait_pct = 0, ready_pct = 100;
  bit            addr_chk = 1'b1;
  int            issued = 0, beats = 0, got = 0, valid_cycles = 0;
  logic          prev_stall = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  vec_t          vecs[6];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic put(input logic [AW-1:0] a, input logic [31:0] ctrl);
    mem[a]      = 32'hA000_0000 | 32'(a);
    mem[a + 1]  = 32'hB000_0000 | 32'(a);
    mem[a + 2]  = 32'(a) * 3 + 7;
    mem[a + 3]  = ctrl;
  endtask

  // Reference walk: queues expected read addresses and emitted descriptors.
  task automatic model(input logic [AW-1:0] head);
    logic [AW-1:0] p;
    desc_t         d;
    int            n;
    p = {head[AW-1:2], 2'b00};
    n = 0;
    for (int guard = 0; guard < 64; guard++) begin
      for (int k = 0; k < 4; k++) addr_q.push_back(p + AW'(k));
      d = {mem[p], mem[p + 1], mem[p + 2], mem[p + 3]};
      if (!d.ctrl[31]) break;
      exp_q.push_back(d);
      n++;
      if (d.ctrl[30] || n == MAXD) break;
      p = {d.ctrl[AW-1:2], 2'b00};
    end
  endtask

  // Slave + stream monitor: drives inputs at negedge, then observes what the
  // DUT will commit at the coming posedge.
  initial begin
    forever begin
      @(negedge clk);
      if (resp_q.size() > 0) begin
        m_readdatavalid = 1'b1;
        m_readdata      = resp_q.pop_front();
        beats++;
      end else begin
        m_readdatavalid = 1'b0;
        m_readdata      = '0;
      end
      m_waitrequest = ($urandom_range(99) < wait_pct);
      desc_ready    = ($urandom_range(99) < ready_pct);
      #1;
      if (!reset_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) check("addr_hold", {m_read, m_address}, {1'b1, prev_addr});
        prev_stall = m_read && m_waitrequest;
        prev_addr  = m_address;
        if (m_read && !m_waitrequest) begin
          issued++;
          resp_q.push_back(mem[m_address]);
          if (addr_chk) begin
            check("read_expected", addr_q.size() > 0, 1);
            if (addr_q.size() > 0) check("read_addr", m_address, addr_q.pop_front());
          end
        end
        if (desc_valid) begin
          valid_cycles++;
          check("desc_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            check("desc_words", {desc_src, desc_dst, desc_len, desc_ctrl}, exp_q[0]);
            if (desc_ready) begin
              void'(exp_q.pop_front());
              got++;
            end
          end
        end
      end
    end
  end

  task automatic pulse_start(input logic [AW-1:0] head);
    @(negedge clk);
    start    = 1'b1;
    head_ptr = head;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic wait_done(input logic [2:0] exp_status, input logic exp_aborted);
    int         cyc;
    logic [2:0] st;
    cyc = 0;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check("done_seen", done, 1);
    check("status", status, exp_status);
    check("aborted", aborted, exp_aborted);
    st = status;
    @(negedge clk);
    check("done_pulse", {done, busy}, 2'b00);
    check("status_held", status, st);
  endtask

  task automatic run_walk(input vec_t v);
    wait_pct  = v.wait_pct;
    ready_pct = v.ready_pct;
    got       = 0;
    model(v.head);
    pulse_start(v.head);
    wait_done(v.exp_status, 1'b0);
    check("desc_count", got, v.exp_count);
    check("scoreboard_empty", exp_q.size(), 0);
    check("reads_all_seen", addr_q.size(), 0);
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    put(10'h010, 32'hC000_0000);
    put(10'h000, 32'h8000_0020);
    put(10'h020, 32'h8000_0040);
    put(10'h040, 32'hC000_0000);
    put(10'h080, 32'h8000_0090);
    put(10'h090, 32'h0000_0000);
    put(10'h100, 32'h8000_0100);
    put(10'h3FC, 32'hC000_0000);
    put(10'h200, 32'hC000_0000);

    vecs[0] = '{10'h010,  0, 100, 3'b001, 1};
    vecs[1] = '{10'h000, 50,  50, 3'b001, 3};
    vecs[2] = '{10'h080, 30,  70, 3'b010, 1};
    vecs[3] = '{10'h100, 20,  60, 3'b100, 4};
    vecs[4] = '{10'h013, 40,  40, 3'b001, 1};
    vecs[5] = '{10'h3FC, 50,  50, 3'b001, 1};

    #1;
    check("rst_master", {m_read, m_address}, '0);
    check("rst_desc", {desc_valid, desc_src, desc_dst, desc_len, desc_ctrl}, '0);
    check("rst_ctrl", {busy, done, status, aborted}, '0);
    @(negedge clk);
    reset_n = 1'b1;

    // Abort is meaningless in IDLE.
    @(negedge clk);
    abort = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_idle_busy", busy, 0);
    abort = 1'b0;

    foreach (vecs[i]) run_walk(vecs[i]);

    // Zero-wait latency: m_read in cycle 1, desc_valid in cycle 7.
    wait_pct  = 0;
    ready_pct = 100;
    got       = 0;
    model(10'h010);
    pulse_start(10'h010);
    cyc = 1;
    check("first_read", {m_read, m_address}, {1'b1, 10'h010});
    while (!desc_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("valid_latency", cyc, 7);
    wait_done(3'b001, 1'b0);

    // Inter-descriptor gap: handshake in cycle N, next read in N+1.
    model(10'h000);
    pulse_start(10'h000);
    cyc = 0;
    while (!desc_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    check("gap_read", {m_read, m_address}, {1'b1, 10'h020});
    wait_done(3'b001, 1'b0);
    check("gap_scoreboard", exp_q.size(), 0);

    // Abort after the second read: both beats drained, nothing emitted, start ignored.
    addr_chk     = 1'b0;
    issued       = 0;
    beats        = 0;
    valid_cycles = 0;
    pulse_start(10'h200);
    cyc = 0;
    while (issued < 2 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    abort    = 1'b1;
    start    = 1'b1;
    head_ptr = 10'h010;
    @(negedge clk);
    start = 1'b0;
    wait_done(3'b100, 1'b1);
    abort = 1'b0;
    check("abort_issued", issued, 2);
    check("abort_drained", beats, issued);
    check("abort_no_valid", valid_cycles, 0);
    repeat (3) @(negedge clk);
    check("start_while_busy_ignored", busy, 0);
    addr_chk = 1'b1;

    // Reset during OUT clears outputs immediately; a fresh walk works afterwards.
    ready_pct = 0;
    model(10'h000);
    pulse_start(10'h000);
    cyc = 0;
    while (!desc_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("reached_out", desc_valid, 1);
    reset_n = 1'b0;
    #1;
    check("rst_mid_walk", {desc_valid, busy, m_read, status, aborted}, '0);
    exp_q.delete();
    addr_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    run_walk(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/nios_system_descriptor_fetch.md
# nios_system_descriptor_fetch

Descriptor fetch engine sitting directly upstream of the DMA datapath and downstream of the 1024 x 32 on-chip descriptor memory. It walks a linked chain of 4-word descriptors through an Avalon-MM read master. Each descriptor owned by hardware is presented on a valid/ready stream. The walk stops at end-of-chain, at a descriptor not owned by hardware, on abort, or when a loop-guard limit is reached.

## Interface
- MAX_DESC, 256: maximum descriptors per chain walk; reaching it terminates with err_loop.
- ADDR_W, 10: word-address width of the descriptor memory.
- clk  in  1  single clock for all logic.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a walk at head_ptr; accepted only in IDLE.
- head_ptr  in  ADDR_W  word address of the first descriptor; bits [1:0] forced to 0.
- abort  in  1  level; stops the walk at the next safe point.
- m_address  out  ADDR_W  read word address.
- m_read  out  1  read request; held with m_address stable while m_waitrequest=1.
- m_waitrequest  in  1  stall for the current request.
- m_readdatavalid  in  1  response beat valid; responses return in order.
- m_readdata  in  32  response data.
- desc_valid  out  1  descriptor available.
- desc_ready  in  1  downstream accepts when desc_valid & desc_ready.
- desc_src, desc_dst, desc_len, desc_ctrl  out  32 each  descriptor words 0..3.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a walk terminates.
- status  out  3  [0] eoc_stop, [1] not_owned_stop, [2] err_loop/aborted; valid with done, held until the next start.
- aborted  out  1  set with done when the walk ended by abort; held until the next start.

## Operation
- Descriptor at word address P (P[1:0]=0): word0 src, word1 dst, word2 length, word3 ctrl.
- ctrl fields: bit31 OWN (hardware owned), bit30 EOC, bits[ADDR_W-1:0] next pointer (low 2 bits forced to 0).
- States: IDLE, FETCH, CHECK, OUT, DONE.
- IDLE -> FETCH on start. Latches ptr = {head_ptr[9:2], 2'b00}, clears desc count, status and aborted.
- FETCH:
  - Issues 4 reads at ptr+0..ptr+3, back-to-back; a read advances when m_waitrequest=0.
  - Issue counter (0..4) and receive counter (0..4) run independently.
  - Beat k captures m_readdata into word k.
  - Exits to CHECK when 4 beats have been received.
- CHECK (1 cycle):
  - OWN=0 -> DONE with not_owned_stop; nothing emitted.
  - Otherwise -> OUT and increments the desc count.
- OUT:
  - desc_valid=1; desc_* held stable until the handshake.
  - On handshake: EOC=1 -> DONE with eoc_stop.
  - Else desc count == MAX_DESC -> DONE with err_loop.
  - Else ptr = next pointer, -> FETCH.
- DONE: done=1 for exactly one cycle, then -> IDLE.
- Abort:
  - Sampled in FETCH, CHECK and OUT.
  - In FETCH: issuing stops, all outstanding beats are drained (receive counter == issue counter), then -> DONE with aborted=1, status[2]=1.
  - In CHECK: -> DONE with aborted=1.
  - In OUT with desc_valid high: the current descriptor stays valid until accepted, then -> DONE with aborted=1.
  - Abort has no effect in IDLE.
- start while busy is ignored.
- Address arithmetic is ADDR_W-bit modulo. P aligned to 4 means ptr+3 never wraps.
- A next pointer equal to the current descriptor is legal; the loop guard bounds the walk.

## Timing
- Reset values:
  - m_read=0, m_address=0.
  - desc_valid=0, desc_*=0.
  - busy=0, done=0, status=0, aborted=0.
  - State IDLE, counters 0.
- Timing from start (cycle 0):
  - m_read asserted in cycle 1.
  - With zero wait states and 1-cycle read latency: reads in cycles 1-4, beats in cycles 2-5, CHECK in cycle 6, desc_valid in cycle 7.
- Inter-descriptor gap: handshake at cycle N gives next m_read in cycle N+1.
- m_read never asserts when 4 reads have already been issued for the current descriptor.
- m_readdatavalid in IDLE is ignored.
- reset_n low mid-walk clears everything immediately. Outstanding responses after reset release arrive in IDLE and are ignored.

## Test plan
- Single descriptor at 0x010, ctrl=0xC000_0000, desc_ready=1 -> one descriptor with desc_ctrl=0xC000_0000, done, status=3'b001, m_address sequence 0x010..0x013.
- Chain 0x000 -> 0x020 -> 0x040 (last EOC), desc_ready toggled randomly, m_waitrequest asserted 50% -> exactly 3 descriptors in order, each held stable while stalled, status=3'b001.
- Second descriptor ctrl=0x0000_0000 (OWN=0) -> one descriptor emitted, done with status=3'b010.
- Self-loop at 0x100 (next=0x100, OWN=1, EOC=0), MAX_DESC=4 -> 4 descriptors, done, status[2]=1, aborted=0.
- Abort asserted after the second read request is issued -> both beats drained, no desc_valid, done with aborted=1; a start issued while busy has no effect.
- reset_n pulsed low during OUT -> desc_valid=0 and busy=0 immediately; a new start afterwards fetches head_ptr correctly.
